// File: rtl/sram_fifo_ctrl.sv
// Valid/ready FIFO controller for a single-port 1rw SRAM macro with 1-cycle read
// latency, hidden behind a 2-entry output prefetch buffer.
module sram_fifo_ctrl #(
  parameter int DATA_WIDTH = 150,
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   mem_cnt_q, mem_cnt_d;
  logic                  rd_inflight_q, rd_inflight_d;
  logic [1:0]            obuf_cnt_q, obuf_cnt_d;
  logic [DATA_WIDTH-1:0] obuf0_q, obuf0_d;
  logic [DATA_WIDTH-1:0] obuf1_q, obuf1_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;

  logic       pop, urgent, wr, rd, mem_empty, space_ok;
  logic [2:0] held;

  // A read may issue only if its word still has an obuf slot when it returns.
  assign pop       = (obuf_cnt_q != 2'd0) && out_ready;
  assign held      = 3'(obuf_cnt_q) + 3'(rd_inflight_q);
  assign space_ok  = held < (3'd2 + 3'(pop));
  assign mem_empty = (mem_cnt_q == '0);
  assign urgent    = (obuf_cnt_q == 2'd0) && !rd_inflight_q && !mem_empty;
  assign in_ready  = !rst && (mem_cnt_q != FULL_CNT) && !urgent;
  assign wr        = in_valid && in_ready;
  assign rd        = !rst && !wr && !mem_empty && space_ok;

  assign out_valid = (obuf_cnt_q != 2'd0);
  assign out_data  = obuf0_q;
  assign level     = (ADDR_WIDTH+2)'(mem_cnt_q) + (ADDR_WIDTH+2)'(rd_inflight_q)
                   + (ADDR_WIDTH+2)'(obuf_cnt_q);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    sram_csb0     = 1'b1;
    sram_web0     = 1'b1;
    sram_addr0    = addr_q;
    sram_din0     = din_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    rd_inflight_d = rd;
    if (rst) begin
      sram_addr0 = '0;
      sram_din0  = '0;
    end else if (wr) begin
      sram_csb0  = 1'b0;
      sram_web0  = 1'b0;
      sram_addr0 = wr_ptr_q;
      sram_din0  = in_data;
      wr_ptr_d   = wr_ptr_q + 1'b1;
    end else if (rd) begin
      sram_csb0  = 1'b0;
      sram_addr0 = rd_ptr_q;
      rd_ptr_d   = rd_ptr_q + 1'b1;
    end
    addr_d = sram_addr0;
    din_d  = sram_din0;

    mem_cnt_d = mem_cnt_q;
    if (wr)      mem_cnt_d = mem_cnt_q + 1'b1;
    else if (rd) mem_cnt_d = mem_cnt_q - 1'b1;
  end

  // Return path: the word read last cycle enters obuf; obuf0 is always the head.
  always_comb begin
    obuf0_d    = obuf0_q;
    obuf1_d    = obuf1_q;
    obuf_cnt_d = obuf_cnt_q;
    unique case ({rd_inflight_q, pop})
      2'b10: begin
        if (obuf_cnt_q == 2'd0) obuf0_d = sram_dout0;
        else                    obuf1_d = sram_dout0;
        obuf_cnt_d = obuf_cnt_q + 1'b1;
      end
      2'b01: begin
        obuf0_d    = obuf1_q;
        obuf_cnt_d = obuf_cnt_q - 1'b1;
      end
      2'b11: begin
        if (obuf_cnt_q == 2'd1) begin
          obuf0_d = sram_dout0;
        end else begin
          obuf0_d = obuf1_q;
          obuf1_d = sram_dout0;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mem_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
      obuf_cnt_q    <= 2'd0;
      addr_q        <= '0;
      din_q         <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_cnt_q     <= mem_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      obuf_cnt_q    <= obuf_cnt_d;
      addr_q        <= addr_d;
      din_q         <= din_d;
    end
  end

  // NOTE: obuf payload is not reset; obuf_cnt_q alone says which entries are live.
  always_ff @(posedge clk) begin
    obuf0_q <= obuf0_d;
    obuf1_q <= obuf1_d;
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Self-checking bench for sram_fifo_ctrl: behavioural 1rw SRAM, queue scoreboard,
// per-cycle port-protocol checks and directed/random scenarios.
module tb_sram_fifo_ctrl;

  localparam int DW = 150;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW+1:0] level;
  logic          sram_csb0, sram_web0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout0;

  sram_fifo_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  always #5 clk = ~clk;

  // Behavioural 1rw macro: read data appears the cycle after the access.
  logic [DW-1:0] mem [512];
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) mem[sram_addr0] <= sram_din0;
      else            sram_dout0 <= mem[sram_addr0];
    end
  end

  int n_total = 0;
  int n_bad   = 0;

  logic [DW-1:0] sb [$];
  logic [AW-1:0] exp_wa = '0;
  logic [AW-1:0] exp_ra = '0;
  logic          stall_q = 1'b0;
  logic [DW-1:0] stall_d = '0;

  logic          s_ready, s_csb, s_web, s_ov, s_hs, s_pop;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_od;
  logic [AW+1:0] s_level;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // One clock cycle: drive inputs after negedge, sample settled outputs, score.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic rs);
    logic [DW-1:0] front;
    @(negedge clk);
    rst = rs; in_valid = v; in_data = d; out_ready = r;
    #1;
    s_ready = in_ready; s_csb = sram_csb0; s_web = sram_web0; s_addr = sram_addr0;
    s_ov = out_valid; s_od = out_data; s_level = level;
    s_hs = in_valid && in_ready;
    s_pop = out_valid && out_ready;
    if (rs) begin
      check("rst_ports", {in_ready, sram_csb0, sram_web0, sram_addr0, sram_din0},
            {1'b0, 1'b1, 1'b1, 9'd0, 150'd0});
      sb.delete();
      exp_wa = '0; exp_ra = '0; stall_q = 1'b0;
    end else begin
      check("level", 192'(level), 192'(sb.size()));
      if (sb.size() == 0) check("empty_no_out", 192'(out_valid), 192'd0);
      if (sb.size() == 0 && !s_hs) check("empty_no_access", 192'(sram_csb0), 192'd1);
      if (stall_q) check("stall_stable", {out_valid, out_data}, {1'b1, stall_d});
      if (s_hs) begin
        check("wr_access", {sram_csb0, sram_web0, sram_addr0, sram_din0},
              {1'b0, 1'b0, exp_wa, in_data});
        exp_wa++;
        sb.push_back(in_data);
      end else if (!sram_csb0) begin
        check("rd_access", {sram_web0, sram_addr0}, {1'b1, exp_ra});
        exp_ra++;
      end
      if (s_pop) begin
        check("pop_has_word", 192'(sb.size() != 0), 192'd1);
        if (sb.size() != 0) begin
          front = sb.pop_front();
          check("pop_data", 192'(out_data), 192'(front));
        end
      end
      stall_q = out_valid && !out_ready;
      stall_d = out_data;
    end
  endtask

  task automatic do_reset();
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic drain(input int budget, output int cycles);
    cycles = 0;
    while (sb.size() > 0 && cycles < budget) begin
      step(1'b0, '0, 1'b1, 1'b0);
      cycles++;
    end
    check("drain_done", 192'(sb.size()), 192'd0);
  endtask

  initial begin
    int pushed;
    int cyc;
    int seen;

    // Single word latency from reset.
    do_reset();
    step(1'b1, 150'h15A, 1'b0, 1'b0);
    check("t1_in_ready", 192'(s_ready), 192'd1);
    check("t1_write", {s_hs, s_csb, s_web, s_addr}, {1'b1, 1'b0, 1'b0, 9'd0});
    step(1'b0, '0, 1'b0, 1'b0);
    check("t1_read", {s_csb, s_web, s_addr, s_ov}, {1'b0, 1'b1, 9'd0, 1'b0});
    step(1'b0, '0, 1'b0, 1'b0);
    check("t1_ov_t2", 192'(s_ov), 192'd0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("t1_ov_t3", {s_ov, s_od}, {1'b1, 150'h15A});
    step(1'b0, '0, 1'b1, 1'b0);
    check("t1_pop", 192'(s_pop), 192'd1);
    step(1'b0, '0, 1'b0, 1'b0);
    check("t1_level0", 192'(s_level), 192'd0);

    // Fill to DEPTH+2 with the consumer stalled.
    do_reset();
    pushed = 0;
    for (int c = 0; c < 3000 && pushed < 514; c++) begin
      step(1'b1, DW'(pushed), 1'b0, 1'b0);
      if (s_hs) pushed++;
    end
    check("fill_count", 192'(pushed), 192'd514);
    for (int c = 0; c < 3; c++) begin
      step(1'b1, '1, 1'b0, 1'b0);
      check("full_in_ready", 192'(s_ready), 192'd0);
      check("full_level", 192'(s_level), 192'd514);
    end

    // Drain from full: one word per cycle, in_ready back after first read.
    step(1'b0, '0, 1'b1, 1'b0);
    check("drain_first", {s_ready, s_csb, s_web, s_pop}, {1'b0, 1'b0, 1'b1, 1'b1});
    step(1'b0, '0, 1'b1, 1'b0);
    check("drain_ready_back", 192'(s_ready), 192'd1);
    drain(2000, cyc);
    check("drain_cycles", 192'(cyc + 2), 192'd514);

    // Simultaneous push and pop.
    pushed = 0;
    for (int c = 0; c < 20000 && pushed < 2000; c++) begin
      step(1'b1, rnd_word(), 1'b1, 1'b0);
      if (s_hs) pushed++;
    end
    check("steady_count", 192'(pushed), 192'd2000);
    drain(3000, cyc);

    // Random backpressure with ~30% out_ready.
    for (int c = 0; c < 1500; c++) begin
      step(1'($urandom_range(0, 1)), rnd_word(), $urandom_range(0, 9) < 3, 1'b0);
    end
    drain(3000, cyc);

    // Reset in the cycle after a read issue drops the returning word.
    do_reset();
    step(1'b1, 150'h111, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("mr_read_issued", {s_csb, s_web}, {1'b0, 1'b1});
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    check("mr_cleared", {s_ov, s_level}, {1'b0, 11'd0});
    step(1'b1, 150'hABC, 1'b0, 1'b0);
    check("mr_push", 192'(s_hs), 192'd1);
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      if (s_pop) begin
        seen = 1;
        check("mr_first_word", 192'(s_od), 192'h0ABC);
      end
    end
    check("mr_popped", 192'(seen), 192'd1);
    step(1'b0, '0, 1'b0, 1'b0);
    check("mr_level0", {s_ov, s_level}, {1'b0, 11'd0});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
